frame_capture: RTL

FRAME_CAPTURE -- requirements
Module: frame_capture

---
 rtl/frame_capture.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/frame_capture.sv
// Frame grabber: discards SKIP leading samples, stores one WIDTH*HEIGHT frame, then streams it out with valid/ready.
// Optional capture checksum is enabled by defining CAPTURE_CHECKSUM_EN.
module frame_capture #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int SKIP   = WIDTH + 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  pixel_in,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  pixel_out,
    output logic        done,
    output logic [15:0] checksum
);

    localparam int DEPTH     = WIDTH * HEIGHT;
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW        = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int SKIP_LAST = (SKIP > 0) ? SKIP - 1 : 0;
    localparam bit SKIP_EN   = (SKIP > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_CAPTURE,
        S_READOUT
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [7:0]    r_mem [DEPTH];
    logic [SW-1:0] r_skip_cnt;
    logic [AW-1:0] r_wr_addr;
    logic [AW:0]   r_rd_cnt;
    logic          r_out_valid;
    logic [7:0]    r_pixel_out;
    logic          r_done;

    logic          w_start_ok;
    logic          w_skip_en;
    logic          w_skip_last;
    logic          w_wr_en;
    logic          w_wr_last;
    logic          w_hs;
    logic          w_all_loaded;
    logic          w_rd_en;
    logic          w_last_hs;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_skip_en    = (r_state == S_SKIP) && in_valid;
    assign w_skip_last  = w_skip_en && (r_skip_cnt == SW'(SKIP_LAST));
    assign w_wr_en      = (r_state == S_CAPTURE) && in_valid;
    assign w_wr_last    = w_wr_en && (r_wr_addr == AW'(DEPTH - 1));
    assign w_hs         = r_out_valid && out_ready;
    assign w_all_loaded = (r_rd_cnt == (AW+1)'(DEPTH));
    // The read data lands directly in the output register, so a load is allowed
    // whenever that register is empty or is being drained this cycle.
    assign w_rd_en      = (r_state == S_READOUT) && !r_done && !w_all_loaded &&
                          (!r_out_valid || out_ready);
    assign w_last_hs    = (r_state == S_READOUT) && w_hs && w_all_loaded;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Done is raised while still in READOUT so start on the done cycle is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = SKIP_EN ? S_SKIP : S_CAPTURE;
                end
            end
            S_SKIP: begin
                if (w_skip_last) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_wr_last) begin
                    w_next = S_READOUT;
                end
            end
            S_READOUT: begin
                if (r_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_cnt  <= '0;
            r_wr_addr   <= '0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last_hs;
            if (w_start_ok) begin
                r_skip_cnt <= '0;
                r_wr_addr  <= '0;
                r_rd_cnt   <= '0;
            end
            if (w_skip_en) begin
                r_skip_cnt <= w_skip_last ? '0 : r_skip_cnt + SW'(1);
            end
            if (w_wr_en) begin
                r_wr_addr <= w_wr_last ? '0 : r_wr_addr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_cnt    <= r_rd_cnt + (AW+1)'(1);
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
            if (r_done) begin
                r_rd_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_out <= '0;
        end else if (w_rd_en) begin
            r_pixel_out <= r_mem[r_rd_cnt[AW-1:0]];
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_wr_en) begin
            r_checksum <= r_checksum + {8'd0, pixel_in};
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign pixel_out = r_pixel_out;
    assign done      = r_done;

endmodule
